modulo_counter: RTL and testbench
=================================

MODULO_COUNTER -- requirements
Module: modulo_counter

Interface
REQ-001 SHALL provide parameter SIZE, default 5, the width of count and load_value in bits.
REQ-002 SHALL provide parameter MODULO, default 32, the number of count states (0..MODULO-1); legal range 2..2^SIZE.
REQ-003 SHALL provide port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL provide port enable  input  1  count one step this cycle.
REQ-006 SHALL provide port up  input  1  direction: 1 increments, 0 decrements.
REQ-007 SHALL provide port load  input  1  synchronous load of load_value.
REQ-008 SHALL provide port load_value  input  SIZE  value to load.
REQ-009 SHALL provide port clear  input  1  synchronous clear to 0.
REQ-010 SHALL provide port count  output  SIZE  registered current count.
REQ-011 SHALL provide port terminal  output  1  combinational: count==MODULO-1 when up=1, count==0 when up=0.
REQ-012 SHALL provide port wrap  output  1  registered one-cycle pulse, set by the edge at which count wrapped or saturated.
REQ-013 SHALL provide port load_error  output  1  registered one-cycle pulse, set by the edge that accepted an out-of-range load.

Function
REQ-014 SHALL apply per-edge priority: clear, then load, then enable; lower-priority inputs are ignored that cycle.
REQ-015 SHALL, on clear=1, set count to 0 with wrap=0 and load_error=0 on the next cycle.
REQ-016 SHALL, on load=1 with load_value<MODULO, set count to load_value with load_error=0.
REQ-017 SHALL, on load=1 with load_value>=MODULO, set count to MODULO-1 with load_error=1 for exactly one cycle.
REQ-018 SHALL, on enable=1 and up=1, set count to count+1; at count==MODULO-1, set count to 0 and wrap=1.
REQ-019 SHALL, on enable=1 and up=0, set count to count-1; at count==0, set count to MODULO-1 and wrap=1.
REQ-020 SHALL hold count and drive wrap=0 and load_error=0 when clear, load and enable are all 0.
REQ-021 SHALL update count one edge after the inputs are sampled; there is no further pipeline latency.
REQ-022 SHALL never present count>=MODULO, including when MODULO<2^SIZE and when direction reverses mid-count.
REQ-023 SHALL compute next-count arithmetic at SIZE+1 bits so that MODULO=2^SIZE wraps correctly without overflow aliasing.
REQ-024 SHALL let up change on any cycle with effect on the next enabled step only.

Reset
REQ-025 SHALL, while reset=0, immediately force count=0, wrap=0 and load_error=0, independent of clock.
REQ-026 SHALL hold that reset state until the first rising clock edge after reset returns to 1.
REQ-027 SHALL discard any load, clear or enable in progress when reset asserts mid-operation.

Configuration
REQ-028 SHALL, with macro MODULO_COUNTER_SATURATE_EN defined, saturate instead of wrapping: enabled up at MODULO-1 holds MODULO-1, enabled down at 0 holds 0, and wrap pulses for one cycle on each such blocked step.
REQ-029 SHALL, without MODULO_COUNTER_SATURATE_EN, wrap as in REQ-018 and REQ-019; the port list is identical in both builds.

Verification
REQ-030 SHALL cover wrap up: SIZE=5, MODULO=10, load 9, enable=1, up=1 -> count=0 next cycle, wrap=1 for exactly one cycle, then count=1 with wrap=0.
REQ-031 SHALL cover wrap down: MODULO=10, count=0, enable=1, up=0 -> count=9, wrap=1; terminal=1 while count=0 and up=0.
REQ-032 SHALL cover priority: clear=1, load=1 (load_value=7) and enable=1 in the same cycle -> count=0; load=1 and enable=1 -> count=7.
REQ-033 SHALL cover the out-of-range load: MODULO=10, load_value=25 -> count=9, load_error=1 for one cycle.
REQ-034 SHALL cover asynchronous reset: reset=0 driven mid-cycle with count=6 -> count=0 before the next clock edge; the count holds 0 until the first edge after reset=1.
REQ-035 SHALL cover the SATURATE_EN build: count=9 (MODULO=10) with up enabled for 3 cycles -> count stays 9 and wrap=1 on each cycle.

Source files
------------

// File: rtl/modulo_counter.sv
// modulo_counter: MODULO-state up/down counter with clear, load, wrap and load-error pulses.
// Build option: define MODULO_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
`default_nettype none

module modulo_counter #(
  parameter int SIZE   = 5,
  parameter int MODULO = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  input  logic            clear,
  output logic [SIZE-1:0] count,
  output logic            terminal,
  output logic            wrap,
  output logic            load_error
);

  localparam logic [SIZE:0]   MODULO_EXT = (SIZE+1)'(MODULO);
  localparam logic [SIZE-1:0] MAX_VAL    = SIZE'(MODULO - 1);

  logic [SIZE-1:0] count_q, count_d;
  logic            wrap_q, wrap_d;
  logic            load_error_q, load_error_d;
  logic [SIZE:0]   count_ext;
  logic [SIZE:0]   inc_ext;
  logic [SIZE:0]   dec_ext;

  // One extra bit so MODULO == 2^SIZE is detected as a carry, and 0-1 as a borrow.
  assign count_ext = {1'b0, count_q};
  assign inc_ext   = count_ext + 1'b1;
  assign dec_ext   = count_ext - 1'b1;

  always_comb begin
    count_d      = count_q;
    wrap_d       = 1'b0;
    load_error_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if ({1'b0, load_value} < MODULO_EXT) begin
        count_d = load_value;
      end else begin
        count_d      = MAX_VAL;
        load_error_d = 1'b1;
      end
    end else if (enable) begin
      if (up) begin
        if (inc_ext == MODULO_EXT) begin
          wrap_d = 1'b1;
`ifdef MODULO_COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
        end else begin
          count_d = inc_ext[SIZE-1:0];
        end
      end else begin
        if (dec_ext[SIZE]) begin
          wrap_d = 1'b1;
`ifdef MODULO_COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = MAX_VAL;
`endif
        end else begin
          count_d = dec_ext[SIZE-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      wrap_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      load_error_q <= load_error_d;
    end
  end

  assign count      = count_q;
  assign wrap       = wrap_q;
  assign load_error = load_error_q;
  assign terminal   = up ? (count_q == MAX_VAL) : (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_modulo_counter.sv
// tb_modulo_counter: scoreboard bench for modulo_counter with SIZE=5, MODULO=10.
`default_nettype none

module tb_modulo_counter;

  localparam int SIZE   = 5;
  localparam int MODULO = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable, up, load, clear;
  logic [SIZE-1:0] load_value;
  logic [SIZE-1:0] count;
  logic            terminal, wrap, load_error;

  typedef struct packed {
    logic [SIZE-1:0] c;
    logic            w;
    logic            e;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_count = 0;

  modulo_counter #(.SIZE(SIZE), .MODULO(MODULO)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .clear      (clear),
    .count      (count),
    .terminal   (terminal),
    .wrap       (wrap),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus from a negedge, push the model's expectation, compare after the edge.
  task automatic step(input logic c, input logic l, input logic [SIZE-1:0] lv,
                      input logic e, input logic u);
    exp_t x;
    int   nxt;
    clear = c; load = l; load_value = lv; enable = e; up = u;
    x.w = 1'b0; x.e = 1'b0;
    nxt = m_count;
    if (c) nxt = 0;
    else if (l) begin
      if (int'(lv) < MODULO) nxt = int'(lv);
      else begin nxt = MODULO - 1; x.e = 1'b1; end
    end else if (e) begin
      if (u) begin
        if (m_count + 1 >= MODULO) begin
          x.w = 1'b1;
`ifdef MODULO_COUNTER_SATURATE_EN
          nxt = m_count;
`else
          nxt = (m_count + 1) % MODULO;
`endif
        end else nxt = m_count + 1;
      end else begin
        if (m_count == 0) begin
          x.w = 1'b1;
`ifdef MODULO_COUNTER_SATURATE_EN
          nxt = 0;
`else
          nxt = (m_count + MODULO - 1) % MODULO;
`endif
        end else nxt = m_count - 1;
      end
    end
    x.c = SIZE'(nxt);
    #1;
    check("terminal", int'(terminal), (u ? (m_count == MODULO - 1) : (m_count == 0)) ? 1 : 0);
    q.push_back(x);
    m_count = nxt;
    @(posedge clock);
    #1;
    x = q.pop_front();
    check("count", int'(count), int'(x.c));
    check("wrap", int'(wrap), int'(x.w));
    check("load_error", int'(load_error), int'(x.e));
    check("range", (int'(count) < MODULO) ? 1 : 0, 1);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; clear = 1'b0; load_value = '0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_lerr", int'(load_error), 0);
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold", int'(count), 0);
    @(negedge clock);
    reset = 1'b1;
    m_count = 0;

    // Wrap up: load 9, then two enabled up steps.
    step(1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);

    // Wrap down from 0.
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Priority.
    step(1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
    step(1'b0, 1'b1, 5'd7, 1'b1, 1'b1);

    // Out-of-range loads, including the largest representable value.
    step(1'b0, 1'b1, 5'd25, 1'b0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 5'd10, 1'b0, 1'b1);
    step(1'b0, 1'b1, 5'd31, 1'b1, 1'b0);

    // Three enabled up steps from 9 (saturate build holds, default build wraps).
    step(1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);

    // Async reset mid-cycle at count 6.
    step(1'b0, 1'b1, 5'd6, 1'b0, 1'b1);
    check("pre_reset", int'(count), 6);
    enable = 1'b1; up = 1'b1; load = 1'b1; load_value = 5'd3;
    #2;
    reset = 1'b0;
    #1;
    check("async_count", int'(count), 0);
    check("async_wrap", int'(wrap), 0);
    @(posedge clock);
    #1;
    check("reset_hold", int'(count), 0);
    @(negedge clock);
    load = 1'b0;
    reset = 1'b1;
    #1;
    check("release_hold", int'(count), 0);
    m_count = 0;
    @(negedge clock);
    m_count = int'(count);
    step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);

    // Random mix with direction reversals.
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           SIZE'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
